// File: rtl/multisim_pull_downsizer.sv
// rtl/multisim_pull_downsizer.sv - splits full-width words into narrow beats, LSB slice first
module multisim_pull_downsizer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_rdy,
    output logic                 out_vld,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_rdy,
    output logic [31:0]          word_cnt
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((OUT_WIDTH < 1) || (IN_WIDTH % OUT_WIDTH != 0)) begin : g_bad_width
            $error("multisim_pull_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IN_WIDTH-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [31:0]           word_cnt_q, word_cnt_d;
    logic                  beat_xfer;
    logic                  word_xfer;

    assign out_vld  = (state_q == BUSY);
    assign out_last = out_vld && (idx_q == LAST_IDX);
    // Combinational path from out_rdy lets a new word load in the same cycle the last beat leaves.
    assign in_rdy   = rst_n && (!out_vld || (out_rdy && out_last));
    assign word_cnt = word_cnt_q;

    assign beat_xfer = out_vld && out_rdy;
    assign word_xfer = in_vld && in_rdy;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx_q == IDX_W'(i)) begin
                out_data = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        word_cnt_d = word_cnt_q;
        // word_xfer while BUSY implies the last beat is leaving this cycle.
        if (word_xfer) begin
            hold_d  = in_data;
            idx_d   = '0;
            state_d = BUSY;
        end else if (beat_xfer) begin
            if (out_last) begin
                state_d = EMPTY;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (beat_xfer && out_last) begin
            word_cnt_d = word_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            hold_q     <= '0;
            idx_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule
